// File: rtl/debug_cmd_rx.sv
// Debug-link command receiver: 8N1 UART plus an ASCII line parser that drives core halt/step/breakpoint controls.
// Latency: rx_valid 1 clk after the mid-stop-bit sample; commands execute on the edge after the terminator's rx_valid.
// Backpressure: none; the serial line cannot be stalled, so every byte is consumed the cycle it arrives.
module debug_cmd_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int MAX_HEX      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        halt,
    output logic        step,
    output logic [15:0] bp_addr,
    output logic        bp_enable,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        cmd_valid,
    output logic        cmd_error
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam int            HW   = $clog2(MAX_HEX + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HEX);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} u_state_t;
    typedef enum logic [1:0] {P_CMD, P_HEX, P_TERM, P_DISCARD} p_state_t;

    logic          rx_m, rx_s;
    u_state_t      u_state, u_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          brk;
    logic          bit_tick, byte_done, frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) u_state <= IDLE;
        else       u_state <= u_next;
    end

    always_comb begin
        u_next = u_state;
        case (u_state)
            IDLE:  if (!rx_s) u_next = START;
            START: if (cnt == HALF) u_next = rx_s ? IDLE : DATA;
            DATA:  if (cnt == LAST && bit_idx == 3'd7) u_next = STOP;
            // After a framing error, hold here until the line is idle so a break cannot look like a new start bit.
            STOP: begin
                if (brk) begin
                    if (rx_s) u_next = IDLE;
                end else if (cnt == LAST && rx_s) begin
                    u_next = IDLE;
                end
            end
            default: u_next = IDLE;
        endcase
    end

    always_comb begin
        bit_tick  = (u_state == DATA) && (cnt == LAST);
        byte_done = (u_state == STOP) && !brk && (cnt == LAST) && rx_s;
        frame_err = (u_state == STOP) && !brk && (cnt == LAST) && !rx_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            brk      <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= byte_done;
            if (u_next != u_state || cnt == LAST) cnt <= '0;
            else                                  cnt <= cnt + 1'b1;
            if (u_state == START) bit_idx <= 3'd0;
            if (bit_tick) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (byte_done) rx_data <= shift;
            if (frame_err)             brk <= 1'b1;
            else if (u_state != STOP)  brk <= 1'b0;
        end
    end

    p_state_t      p_state, p_next;
    logic [7:0]    uc, op;
    logic [3:0]    nibble;
    logic          is_term, is_hex, do_exec, reject;
    logic [15:0]   acc;
    logic [HW-1:0] hex_cnt;

    always_comb begin
        uc      = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? (rx_data & 8'hDF) : rx_data;
        is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_hex  = 1'b0;
        nibble  = 4'h0;
        if (uc >= 8'h30 && uc <= 8'h39) begin
            is_hex = 1'b1;
            nibble = uc[3:0];
        end else if (uc >= 8'h41 && uc <= 8'h46) begin
            is_hex = 1'b1;
            nibble = uc[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) p_state <= P_CMD;
        else       p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (frame_err) begin
            p_next = P_DISCARD;
        end else if (rx_valid) begin
            case (p_state)
                P_CMD: if (!is_term) begin
                    if (uc == "H" || uc == "C" || uc == "S" || uc == "X") p_next = P_TERM;
                    else if (uc == "B")                                 p_next = P_HEX;
                    else                                                p_next = P_DISCARD;
                end
                P_HEX: begin
                    if (is_hex && hex_cnt < HMAX) p_next = P_HEX;
                    else if (is_term)             p_next = P_CMD;
                    else                          p_next = P_DISCARD;
                end
                P_TERM:    p_next = is_term ? P_CMD : P_DISCARD;
                P_DISCARD: if (is_term) p_next = P_CMD;
                default:   p_next = P_CMD;
            endcase
        end
    end

    // A terminator in P_HEX either completes the address or rejects the whole line on the spot.
    always_comb begin
        do_exec = rx_valid && is_term &&
                  ((p_state == P_TERM) || (p_state == P_HEX && hex_cnt == HMAX));
        reject  = rx_valid && is_term &&
                  ((p_state == P_DISCARD) || (p_state == P_HEX && hex_cnt != HMAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op        <= 8'h00;
            acc       <= 16'h0000;
            hex_cnt   <= '0;
            halt      <= 1'b0;
            step      <= 1'b0;
            bp_addr   <= 16'h0000;
            bp_enable <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            step      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_error <= frame_err | reject;
            if (rx_valid && p_state == P_CMD && !is_term) begin
                op      <= uc;
                acc     <= 16'h0000;
                hex_cnt <= '0;
            end
            if (rx_valid && p_state == P_HEX && is_hex && hex_cnt < HMAX) begin
                acc     <= {acc[11:0], nibble};
                hex_cnt <= hex_cnt + 1'b1;
            end
            if (do_exec) begin
                case (op)
                    "H": begin halt <= 1'b1; cmd_valid <= 1'b1; end
                    "C": begin halt <= 1'b0; cmd_valid <= 1'b1; end
                    "S": begin
                        if (halt) begin
                            step      <= 1'b1;
                            cmd_valid <= 1'b1;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                    "B": begin bp_addr <= acc; bp_enable <= 1'b1; cmd_valid <= 1'b1; end
                    "X": begin bp_enable <= 1'b0; cmd_valid <= 1'b1; end
                    default: cmd_error <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_debug_cmd_rx.sv
// Directed bench for debug_cmd_rx: bytes and command outcomes are queued as expected when sent, then checked as the DUT emits them.
module tb_debug_cmd_rx;
    localparam int CPB = 8;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        halt, step, bp_enable, rx_valid, cmd_valid, cmd_error;
    logic [15:0] bp_addr;
    logic [7:0]  rx_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic        e;
        logic        s;
        logic        h;
        logic        be;
        logic [15:0] ba;
        logic        after_rxv;
    } cmd_exp_t;

    logic [7:0] rx_q[$];
    cmd_exp_t   cmd_q[$];
    logic       prev_rxv = 1'b0;
    logic [7:0] eb;
    cmd_exp_t   ec;

    debug_cmd_rx #(.CLKS_PER_BIT(CPB), .MAX_HEX(4)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .halt(halt), .step(step), .bp_addr(bp_addr), .bp_enable(bp_enable),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_cmd(input logic v, input logic e, input logic s, input logic h,
                           input logic be, input logic [15:0] ba, input logic ar);
        cmd_exp_t x;
        x.v = v; x.e = e; x.s = s; x.h = h; x.be = be; x.ba = ba; x.after_rxv = ar;
        cmd_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clk);
        if (!good_stop) begin
            repeat (3 * CPB) @(negedge clk);
            rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic send_char(input logic [7:0] b);
        rx_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic drained(input string tag);
        repeat (4 * CPB) @(negedge clk);
        chk({tag, "_rx_left"}, 32'(rx_q.size()), 32'd0);
        chk({tag, "_cmd_left"}, 32'(cmd_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                if (rx_q.size() == 0) chk("rx_unexpected", 32'(rx_valid), 32'd0);
                else begin
                    eb = rx_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(eb));
                end
            end
            if (cmd_valid || cmd_error || step) begin
                if (cmd_q.size() == 0) chk("cmd_unexpected", 32'({cmd_valid, cmd_error, step}), 32'd0);
                else begin
                    ec = cmd_q.pop_front();
                    chk("cmd_valid", 32'(cmd_valid), 32'(ec.v));
                    chk("cmd_error", 32'(cmd_error), 32'(ec.e));
                    chk("step", 32'(step), 32'(ec.s));
                    chk("halt", 32'(halt), 32'(ec.h));
                    chk("bp_enable", 32'(bp_enable), 32'(ec.be));
                    chk("bp_addr", 32'(bp_addr), 32'(ec.ba));
                    chk("exec_latency", 32'(prev_rxv), 32'(ec.after_rxv));
                end
            end
        end
        prev_rxv = rx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_bp_addr", 32'(bp_addr), 32'd0);
        chk("rst_bp_enable", 32'(bp_enable), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_pulses", 32'({rx_valid, cmd_valid, cmd_error}), 32'd0);
        repeat (2 * CPB) @(negedge clk);

        // 1: halt
        exp_cmd(1, 0, 0, 1, 0, 16'h0000, 1);
        send_str("H"); send_char(CR);
        drained("t1");
        chk("t1_rx_data", 32'(rx_data), 32'h0D);
        chk("t1_halt", 32'(halt), 32'd1);

        // 2: step while halted, continue, step while running
        exp_cmd(1, 0, 1, 1, 0, 16'h0000, 1);
        send_str("S"); send_char(LF);
        exp_cmd(1, 0, 0, 0, 0, 16'h0000, 1);
        send_str("C"); send_char(CR);
        exp_cmd(0, 1, 0, 0, 0, 16'h0000, 1);
        send_str("S"); send_char(CR);
        drained("t2");
        chk("t2_halt", 32'(halt), 32'd0);

        // 3: breakpoint set, short/long rejects, clear
        exp_cmd(1, 0, 0, 0, 1, 16'h1AF3, 1);
        send_str("b1aF3"); send_char(CR);
        exp_cmd(0, 1, 0, 0, 1, 16'h1AF3, 1);
        send_str("B12"); send_char(CR);
        exp_cmd(0, 1, 0, 0, 1, 16'h1AF3, 1);
        send_str("B12345"); send_char(CR);
        exp_cmd(1, 0, 0, 0, 0, 16'h1AF3, 1);
        send_str("X"); send_char(CR);
        drained("t3");

        // 4: framing error on 'H', then the terminator closes the discarded line
        exp_cmd(0, 1, 0, 0, 0, 16'h1AF3, 0);
        send_byte(8'h48, 1'b0);
        exp_cmd(0, 1, 0, 0, 0, 16'h1AF3, 1);
        send_char(CR);
        drained("t4");
        chk("t4_halt", 32'(halt), 32'd0);
        chk("t4_rx_data_kept", 32'(rx_data), 32'h0D);

        // 5: start-bit glitch, bad command, empty lines
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        exp_cmd(0, 1, 0, 0, 0, 16'h1AF3, 1);
        send_str("Hq"); send_char(CR);
        send_char(CR); send_char(LF);
        drained("t5");
        chk("t5_halt", 32'(halt), 32'd0);

        // 6: reset in the middle of a line
        exp_cmd(1, 0, 0, 1, 0, 16'h1AF3, 1);
        send_str("H"); send_char(CR);
        exp_cmd(1, 0, 0, 1, 1, 16'h00FF, 1);
        send_str("B00FF"); send_char(CR);
        send_str("B1");
        rx = 1'b0;
        repeat (2 * CPB + 4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rst_halt", 32'(halt), 32'd0);
        chk("t6_rst_bp_addr", 32'(bp_addr), 32'd0);
        chk("t6_rst_bp_enable", 32'(bp_enable), 32'd0);
        chk("t6_rst_rx_data", 32'(rx_data), 32'd0);
        chk("t6_rst_pulses", 32'({step, rx_valid, cmd_valid, cmd_error}), 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        exp_cmd(1, 0, 0, 1, 0, 16'h0000, 1);
        send_str("H"); send_char(CR);
        drained("t6");
        chk("t6_halt", 32'(halt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
